// File: rtl/ws2812_rx.sv
// ws2812_rx -- WS2812 serial-line receiver.
// Measures each high pulse on the synchronized line, turns it into a bit,
// packs 16 bits per word (MSB first) and numbers words within a frame.
// A long low period ends the frame. Protocol violations pulse 'error'.
// Optional build macro: WS2812_RX_GLITCH_FILTER_EN inserts a 3-sample
// glitch filter after the synchronizer (adds 2 clocks of latency).
module ws2812_rx #(
  parameter int WORDS         = 1305,
  parameter int BIT_THRESHOLD = 31,
  parameter int MIN_HIGH      = 4,
  parameter int MAX_HIGH      = 100,
  parameter int RESET_LOW     = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data,
  output logic [15:0] wordData,
  output logic [10:0] wordAddress,
  output logic        wordStrobe,
  output logic        frameDone,
  output logic [10:0] frameWords,
  output logic        error
);

  localparam logic [14:0] CNT_MAX    = 15'h7fff;
  localparam logic [14:0] THRESH_CNT = 15'(BIT_THRESHOLD);
  localparam logic [14:0] MIN_CNT    = 15'(MIN_HIGH);
  localparam logic [14:0] MAX_CNT    = 15'(MAX_HIGH);
  localparam logic [14:0] LOW_CNT    = 15'(RESET_LOW);
  localparam logic [10:0] ADDR_LIMIT = 11'(WORDS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  logic        sync1_reg;
  logic        sync2_reg;
  logic        din;

  state_t      state_reg;
  logic [14:0] high_count_reg;
  logic [14:0] low_count_reg;
  logic [4:0]  bit_count_reg;
  logic [15:0] shift_reg;
  logic [10:0] addr_reg;
  logic        word_pending_reg;
  logic        overflow_seen_reg;

  // Counters stick at their maximum instead of wrapping.
  function automatic logic [14:0] sat_inc(input logic [14:0] v);
    return (v == CNT_MAX) ? v : v + 15'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= data;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef WS2812_RX_GLITCH_FILTER_EN
  logic hist0_reg;
  logic hist1_reg;
  logic filt_reg;
  logic agree;

  // din follows the line only once three consecutive samples agree;
  // otherwise it holds the last accepted level.
  assign agree = (sync2_reg == hist0_reg) && (hist0_reg == hist1_reg);
  assign din   = agree ? sync2_reg : filt_reg;

  // Sample history and held level for the glitch filter.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist0_reg <= 1'b0;
      hist1_reg <= 1'b0;
      filt_reg  <= 1'b0;
    end else begin
      hist0_reg <= sync2_reg;
      hist1_reg <= hist0_reg;
      filt_reg  <= din;
    end
  end
`else
  assign din = sync2_reg;
`endif

  // Pulse-width decoder, word assembly/delivery and frame bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= SYNC;
      high_count_reg    <= '0;
      low_count_reg     <= '0;
      bit_count_reg     <= '0;
      shift_reg         <= '0;
      addr_reg          <= '0;
      word_pending_reg  <= 1'b0;
      overflow_seen_reg <= 1'b0;
      wordData          <= '0;
      wordAddress       <= '0;
      wordStrobe        <= 1'b0;
      frameDone         <= 1'b0;
      frameWords        <= '0;
      error             <= 1'b0;
    end else begin
      wordStrobe       <= 1'b0;
      frameDone        <= 1'b0;
      error            <= 1'b0;
      word_pending_reg <= 1'b0;

      // A word completed last cycle: deliver it, or flag frame overflow once.
      if (word_pending_reg) begin
        if (addr_reg < ADDR_LIMIT) begin
          wordStrobe  <= 1'b1;
          wordData    <= shift_reg;
          wordAddress <= addr_reg;
          addr_reg    <= addr_reg + 11'd1;
        end else if (!overflow_seen_reg) begin
          error             <= 1'b1;
          overflow_seen_reg <= 1'b1;
        end
      end

      case (state_reg)
        SYNC: begin
          if (din) begin
            low_count_reg <= '0;
          end else if (sat_inc(low_count_reg) >= LOW_CNT) begin
            // Line has been quiet long enough: start a fresh frame.
            low_count_reg     <= '0;
            bit_count_reg     <= '0;
            addr_reg          <= '0;
            overflow_seen_reg <= 1'b0;
            state_reg         <= IDLE;
          end else begin
            low_count_reg <= sat_inc(low_count_reg);
          end
        end

        IDLE: begin
          if (din) begin
            high_count_reg <= 15'd1;
            state_reg      <= HIGH;
          end
        end

        HIGH: begin
          if (din) begin
            if (sat_inc(high_count_reg) > MAX_CNT) begin
              // Stuck-high line: abandon the word and re-synchronize.
              error         <= 1'b1;
              bit_count_reg <= '0;
              low_count_reg <= '0;
              state_reg     <= SYNC;
            end else begin
              high_count_reg <= sat_inc(high_count_reg);
            end
          end else if (high_count_reg < MIN_CNT) begin
            // Too short to be a real bit.
            error         <= 1'b1;
            bit_count_reg <= '0;
            low_count_reg <= '0;
            state_reg     <= SYNC;
          end else begin
            shift_reg     <= {shift_reg[14:0], (high_count_reg > THRESH_CNT)};
            low_count_reg <= 15'd1;
            state_reg     <= LOW;
            if (bit_count_reg == 5'd15) begin
              bit_count_reg    <= '0;
              word_pending_reg <= 1'b1;
            end else begin
              bit_count_reg <= bit_count_reg + 5'd1;
            end
          end
        end

        LOW: begin
          if (din) begin
            high_count_reg <= 15'd1;
            state_reg      <= HIGH;
          end else if (sat_inc(low_count_reg) >= LOW_CNT) begin
            // Frame end; leftover bits are an incomplete word.
            frameDone         <= 1'b1;
            frameWords        <= addr_reg;
            addr_reg          <= '0;
            overflow_seen_reg <= 1'b0;
            if (bit_count_reg != 5'd0) begin
              error <= 1'b1;
            end
            bit_count_reg <= '0;
            low_count_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            low_count_reg <= sat_inc(low_count_reg);
          end
        end

        default: state_reg <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx -- randomized bench for ws2812_rx.
// Two receivers share one serial line: one with the default frame size and
// one limited to 2 words. A pulse-level reference model predicts strobes
// (with exact cycle), error pulses and frame-end word counts.
module tb_ws2812_rx;

  localparam int RESET_LOW = 1000;
  localparam int MIN_HIGH  = 4;
  localparam int MAX_HIGH  = 100;
  localparam int BIT_TH    = 31;
  localparam int GAP       = 1100;
`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam int EXTRA = 2;
  localparam bit FILT  = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit FILT  = 1'b0;
`endif
  localparam int LAT = 3 + EXTRA;
  localparam logic [30:0] ANY_CYC = 31'h7fffffff;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        data  = 1'b0;

  logic [15:0] wd0, wd1;
  logic [10:0] wa0, wa1, fw0, fw1;
  logic        ws0, ws1, fd0, fd1, er0, er1;

  ws2812_rx dut0 (
    .clock(clock), .reset(reset), .data(data),
    .wordData(wd0), .wordAddress(wa0), .wordStrobe(ws0),
    .frameDone(fd0), .frameWords(fw0), .error(er0)
  );

  ws2812_rx #(.WORDS(2)) dut1 (
    .clock(clock), .reset(reset), .data(data),
    .wordData(wd1), .wordAddress(wa1), .wordStrobe(ws1),
    .frameDone(fd1), .frameWords(fw1), .error(er1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event records: strobe {inst, cycle, addr, data}, error {inst, cycle},
  // frame end {inst, words}.
  logic [58:0] exp_str[$], obs_str[$];
  logic [31:0] exp_err[$], obs_err[$];
  logic [11:0] exp_fd[$],  obs_fd[$];

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Monitor: sampled on the falling edge, one line per strobe.
  always @(negedge clock) begin
    if (ws0) begin
      obs_str.push_back({1'b0, 31'(cyc), wa0, wd0});
      $display("cycle %0d inst0 strobe addr %0d data 0x%04h", cyc, wa0, wd0);
    end
    if (ws1) begin
      obs_str.push_back({1'b1, 31'(cyc), wa1, wd1});
      $display("cycle %0d inst1 strobe addr %0d data 0x%04h", cyc, wa1, wd1);
    end
    if (er0) obs_err.push_back({1'b0, 31'(cyc)});
    if (er1) obs_err.push_back({1'b1, 31'(cyc)});
    if (fd0) begin
      obs_fd.push_back({1'b0, fw0});
      $display("cycle %0d inst0 frame end words %0d", cyc, fw0);
    end
    if (fd1) begin
      obs_fd.push_back({1'b1, fw1});
      $display("cycle %0d inst1 frame end words %0d", cyc, fw1);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (pulse level) ----------------
  int          m_words[2] = '{1305, 2};
  bit          m_synced   = 1'b0;
  bit          m_in_frame = 1'b0;
  int          m_nbits    = 0;
  logic [15:0] m_word     = '0;
  int          m_addr[2]  = '{0, 0};
  bit          m_ovf[2]   = '{1'b0, 1'b0};

  task automatic model_clear();
    m_in_frame = 1'b0;
    m_nbits    = 0;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  // s: first edge sampling the line high; e0: first edge sampling it low.
  task automatic model_pulse(input int hi, input int s, input int e0);
    if (FILT && hi < 3) return;
    if (!m_synced) return;
    if (hi > MAX_HIGH) begin
      for (int k = 0; k < 2; k++)
        exp_err.push_back({k[0], 31'(s + MAX_HIGH + 2 + EXTRA)});
      m_synced = 1'b0;
      model_clear();
    end else if (hi < MIN_HIGH) begin
      for (int k = 0; k < 2; k++)
        exp_err.push_back({k[0], 31'(e0 + 2 + EXTRA)});
      m_synced = 1'b0;
      model_clear();
    end else begin
      m_word     = {m_word[14:0], (hi > BIT_TH)};
      m_nbits    = m_nbits + 1;
      m_in_frame = 1'b1;
      if (m_nbits == 16) begin
        m_nbits = 0;
        for (int k = 0; k < 2; k++) begin
          if (m_addr[k] < m_words[k]) begin
            exp_str.push_back({k[0], 31'(e0 + LAT), 11'(m_addr[k]), m_word});
            m_addr[k] = m_addr[k] + 1;
          end else if (!m_ovf[k]) begin
            m_ovf[k] = 1'b1;
            exp_err.push_back({k[0], 31'(e0 + LAT)});
          end
        end
      end
    end
  endtask

  task automatic model_low(input int lo);
    if (lo < RESET_LOW) return;
    if (!m_synced) begin
      m_synced = 1'b1;
      model_clear();
    end else if (m_in_frame) begin
      for (int k = 0; k < 2; k++) begin
        exp_fd.push_back({k[0], 11'(m_addr[k])});
        if (m_nbits != 0) exp_err.push_back({k[0], ANY_CYC});
      end
      model_clear();
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic lvl, input int n);
    data = lvl;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    int s, e0;
    s  = cyc + 1;
    drive(1'b1, hi);
    e0 = cyc + 1;
    drive(1'b0, lo);
    model_pulse(hi, s, e0);
    model_low(lo);
  endtask

  task automatic send_low(input int n);
    drive(1'b0, n);
    model_low(n);
  endtask

  task automatic send_bit(input bit b, input bit fixed);
    int hi, lo, r;
    if (fixed) begin
      hi = b ? 49 : 13;
      lo = b ? 13 : 49;
    end else begin
      r = int'($urandom_range(0, 9));
      if (b) hi = (r == 0) ? BIT_TH + 1 : (r == 1) ? MAX_HIGH : int'($urandom_range(33, 99));
      else   hi = (r == 0) ? MIN_HIGH   : (r == 1) ? BIT_TH   : int'($urandom_range(5, 30));
      lo = int'($urandom_range(5, 40));
    end
    send_pulse(hi, lo);
  endtask

  // Sends the first nbits of w, MSB first.
  task automatic send_word(input logic [15:0] w, input int nbits, input bit fixed);
    for (int i = 15; i > 15 - nbits; i--) send_bit(w[i], fixed);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    m_synced = 1'b0;
    model_clear();
  endtask

  initial begin
    int nw;
    data  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_wordData",    wd0, 16'h0);
    check_val("reset_wordAddress", wa0, 11'h0);
    check_val("reset_wordStrobe",  ws0, 1'b0);
    check_val("reset_frameDone",   fd0, 1'b0);
    check_val("reset_frameWords",  fw0, 11'h0);
    check_val("reset_error",       er0, 1'b0);
    reset = 1'b0;
    send_low(GAP);

    // Single word with nominal timings.
    send_word(16'hA5C3, 16, 1'b1);
    send_low(GAP);

    // Three words: the 2-word receiver overflows on the third.
    send_word(16'h0001, 16, 1'b1);
    send_word(16'hFFFF, 16, 1'b1);
    send_word(16'h8000, 16, 1'b1);
    send_low(GAP);

    // Random frames with randomized pulse widths, including threshold edges.
    for (int f = 0; f < 4; f++) begin
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) send_word(16'($urandom()), 16, 1'b0);
      send_low(GAP);
    end

    // 2-clock spike mid-word, then the rest of the word and one more word.
    send_word(16'hC3A5, 5, 1'b1);
    send_pulse(2, 20);
    send_word(16'h3C5A, 11, 1'b1);
    send_word(16'h0F0F, 16, 1'b1);
    send_low(GAP);
    send_word(16'($urandom()), 16, 1'b0);
    send_low(GAP);

    // Stuck-high pulse mid-word; following bits must be ignored.
    send_word(16'hFFFF, 3, 1'b1);
    send_pulse(150, 20);
    send_word(16'h1111, 4, 1'b1);
    send_low(GAP);
    send_word(16'h5A5A, 16, 1'b1);
    send_low(GAP);

    // Reset after 8 bits, then a complete frame.
    send_word(16'hBEEF, 8, 1'b1);
    pulse_reset();
    send_low(GAP);
    send_word(16'h1234, 16, 1'b1);
    send_low(GAP);

    // Frame ends with a partial word.
    send_word(16'($urandom()), 16, 1'b0);
    send_word(16'hFFFF, 5, 1'b0);
    send_low(GAP);

    check_val("strobe_count", obs_str.size(), exp_str.size());
    for (int i = 0; i < obs_str.size() && i < exp_str.size(); i++)
      check_val($sformatf("strobe[%0d]", i), obs_str[i], exp_str[i]);

    check_val("error_count", obs_err.size(), exp_err.size());
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++) begin
      if (exp_err[i][30:0] == ANY_CYC)
        check_val($sformatf("error_inst[%0d]", i), obs_err[i][31], exp_err[i][31]);
      else
        check_val($sformatf("error[%0d]", i), obs_err[i], exp_err[i]);
    end

    check_val("frame_count", obs_fd.size(), exp_fd.size());
    for (int i = 0; i < obs_fd.size() && i < exp_fd.size(); i++)
      check_val($sformatf("frame[%0d]", i), obs_fd[i], exp_fd[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
